// File: rtl/cam_frame_monitor_if.sv
// Camera stream sideband tap plus the measurement results of cam_frame_monitor.
// master: stream/control source and result consumer; slave: the monitor itself.
interface cam_frame_monitor_if #(
  parameter int DIM_WIDTH = 16
);
  logic                 enable;
  logic                 vsync;
  logic                 de;
  logic [31:0]          frames_per_second;
  logic                 fps_update;
  logic [DIM_WIDTH-1:0] lines_per_frame;
  logic [DIM_WIDTH-1:0] pixels_per_line;
  logic                 frame_stall;
  logic [31:0]          debug_status;

  modport master (
    output enable, vsync, de,
    input  frames_per_second, fps_update, lines_per_frame,
           pixels_per_line, frame_stall, debug_status
  );

  modport slave (
    input  enable, vsync, de,
    output frames_per_second, fps_update, lines_per_frame,
           pixels_per_line, frame_stall, debug_status
  );
endinterface

// File: rtl/cam_frame_monitor.sv
// Passive camera stream monitor: frame rate per window, lines per frame,
// pixels per line and a no-frame stall flag, all as registered outputs.
module cam_frame_monitor #(
  parameter int WINDOW_CYCLES     = 100000000,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
  parameter int DIM_WIDTH         = 16
) (
  input logic                clk,
  input logic                reset,
  cam_frame_monitor_if.slave mon
);

  localparam int                   WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [DIM_WIDTH-1:0] DIM_MAX  = '1;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);

  logic                 vsync_q;
  logic                 de_q;
  logic                 frame_start;
  logic                 line_start;
  logic                 line_end;
  logic                 win_last;
  logic [WIN_W-1:0]     win_cnt;
  logic [31:0]          frame_cnt;
  logic [31:0]          frame_total;
  logic [31:0]          fps_q;
  logic                 fps_update_q;
  logic                 stall_q;
  logic                 stall_next;
  logic [DIM_WIDTH-1:0] line_cnt;
  logic [DIM_WIDTH-1:0] pix_cnt;
  logic [DIM_WIDTH-1:0] lpf_q;
  logic [DIM_WIDTH-1:0] lpf_next;
  logic [DIM_WIDTH-1:0] ppl_q;
  logic [15:0]          lpf_next16;
  logic [31:0]          debug_q;

  assign frame_start = VSYNC_ACTIVE_HIGH ? (mon.vsync & ~vsync_q) : (~mon.vsync & vsync_q);
  assign line_start  = mon.de & ~de_q;
  assign line_end    = ~mon.de & de_q;
  assign win_last    = (win_cnt == WIN_LAST);

  // Frame count including a frame_start on this very cycle, saturating.
  assign frame_total = (frame_start && (frame_cnt != '1)) ? frame_cnt + 32'd1 : frame_cnt;

  // Next values of the result registers, shared with the debug word so all
  // fields of debug_status change on the same edge as their source outputs.
  assign lpf_next   = (mon.enable && frame_start) ? line_cnt : lpf_q;
  assign stall_next = (mon.enable && win_last) ? (frame_total == '0) : stall_q;

  generate
    if (DIM_WIDTH >= 16) begin : g_dbg_trunc
      assign lpf_next16 = lpf_next[15:0];
    end else begin : g_dbg_ext
      assign lpf_next16 = {{(16-DIM_WIDTH){1'b0}}, lpf_next};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      win_cnt      <= '0;
      frame_cnt    <= '0;
      fps_q        <= '0;
      fps_update_q <= 1'b0;
      stall_q      <= 1'b0;
      line_cnt     <= '0;
      pix_cnt      <= '0;
      lpf_q        <= '0;
      ppl_q        <= '0;
      debug_q      <= '0;
    end else begin
      vsync_q      <= mon.vsync;
      de_q         <= mon.de;
      fps_update_q <= 1'b0;
      lpf_q        <= lpf_next;
      stall_q      <= stall_next;
      debug_q      <= {stall_next, mon.enable, 14'd0, lpf_next16};

      if (!mon.enable) begin
        win_cnt   <= '0;
        frame_cnt <= '0;
        line_cnt  <= '0;
        pix_cnt   <= '0;
      end else begin
        if (win_last) begin
          win_cnt      <= '0;
          frame_cnt    <= '0;
          fps_q        <= frame_total;
          fps_update_q <= 1'b1;
        end else begin
          win_cnt   <= win_cnt + 1'b1;
          frame_cnt <= frame_total;
        end

        // A line opening on the frame_start cycle belongs to the new frame.
        if (frame_start) begin
          line_cnt <= line_start ? DIM_ONE : '0;
        end else if (line_start && (line_cnt != DIM_MAX)) begin
          line_cnt <= line_cnt + 1'b1;
        end

        if (line_end) begin
          ppl_q   <= pix_cnt;
          pix_cnt <= '0;
        end else if (mon.de && (pix_cnt != DIM_MAX)) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  assign mon.frames_per_second = fps_q;
  assign mon.fps_update        = fps_update_q;
  assign mon.lines_per_frame   = lpf_q;
  assign mon.pixels_per_line   = ppl_q;
  assign mon.frame_stall       = stall_q;
  assign mon.debug_status      = debug_q;

endmodule

// File: tb/tb_cam_frame_monitor.sv
// Randomized and directed bench for cam_frame_monitor; two instances (rising
// vsync / 16-bit dims and falling vsync / 4-bit dims) share one stimulus.
module tb_cam_frame_monitor;

  localparam int W = 1000;

  logic clk;
  logic reset;
  logic enable;
  logic vsync;
  logic de;

  cam_frame_monitor_if #(.DIM_WIDTH(16)) m0 ();
  cam_frame_monitor_if #(.DIM_WIDTH(4))  m1 ();

  assign m0.enable = enable;
  assign m0.vsync  = vsync;
  assign m0.de     = de;
  assign m1.enable = enable;
  assign m1.vsync  = vsync;
  assign m1.de     = de;

  cam_frame_monitor #(.WINDOW_CYCLES(W), .VSYNC_ACTIVE_HIGH(1'b1), .DIM_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .mon(m0.slave)
  );
  cam_frame_monitor #(.WINDOW_CYCLES(W), .VSYNC_ACTIVE_HIGH(1'b0), .DIM_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .mon(m1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Reference model: timestamps of events, windows aligned to the enable rise.
  int  t;
  int  en_since;
  bit  en_prev, vs_prev, de_prev, exp_en_d;
  int  run_start;
  int  ppl_raw;
  int  lpf_raw  [2];
  int  exp_fps  [2];
  bit  exp_upd  [2];
  bit  exp_stall[2];
  int  lstarts  [2][$];
  int  fstarts  [2][$];

  function automatic int satv(input int v, input int k);
    int mx;
    mx = (k == 0) ? 65535 : 15;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int phase();
    return (t - en_since) % W;
  endfunction

  task automatic model_reset();
    en_since = -1; en_prev = 0; vs_prev = 0; de_prev = 0; exp_en_d = 0;
    run_start = 0; ppl_raw = 0;
    for (int k = 0; k < 2; k++) begin
      lpf_raw[k] = 0; exp_fps[k] = 0; exp_upd[k] = 0; exp_stall[k] = 0;
      lstarts[k].delete(); fstarts[k].delete();
    end
  endtask

  task automatic model_edge();
    bit ls, le, fs;
    int n, first;
    ls = de && !de_prev;
    le = !de && de_prev;
    if (ls) run_start = t;
    for (int k = 0; k < 2; k++) exp_upd[k] = 0;
    if (enable) begin
      if (!en_prev) en_since = t;
      if (le) ppl_raw = t - ((run_start > en_since) ? run_start : en_since);
      for (int k = 0; k < 2; k++) begin
        fs = (k == 0) ? (vsync && !vs_prev) : (!vsync && vs_prev);
        if (fs) begin
          lpf_raw[k] = lstarts[k].size();
          lstarts[k].delete();
          fstarts[k].push_back(t);
        end
        if (ls) lstarts[k].push_back(t);
        if ((t - en_since) % W == W - 1) begin
          first = t - W + 1;
          n = 0;
          for (int i = 0; i < fstarts[k].size(); i++)
            if (fstarts[k][i] >= first) n++;
          exp_fps[k]   = n;
          exp_stall[k] = (n == 0);
          exp_upd[k]   = 1;
          fstarts[k].delete();
        end
      end
    end else begin
      en_since = -1;
      for (int k = 0; k < 2; k++) begin
        lstarts[k].delete(); fstarts[k].delete();
      end
    end
    exp_en_d = enable;
    en_prev  = enable;
    vs_prev  = vsync;
    de_prev  = de;
    t++;
  endtask

  task automatic check_all();
    logic [31:0] dbg0, dbg1;
    dbg0 = {exp_stall[0], exp_en_d, 14'd0, 16'(satv(lpf_raw[0], 0))};
    dbg1 = {exp_stall[1], exp_en_d, 14'd0, 16'(satv(lpf_raw[1], 1))};
    check("fps0",   64'(m0.frames_per_second), 64'(exp_fps[0]));
    check("upd0",   64'(m0.fps_update),        64'(exp_upd[0]));
    check("lpf0",   64'(m0.lines_per_frame),   64'(satv(lpf_raw[0], 0)));
    check("ppl0",   64'(m0.pixels_per_line),   64'(satv(ppl_raw, 0)));
    check("stall0", 64'(m0.frame_stall),       64'(exp_stall[0]));
    check("dbg0",   64'(m0.debug_status),      64'(dbg0));
    check("fps1",   64'(m1.frames_per_second), 64'(exp_fps[1]));
    check("upd1",   64'(m1.fps_update),        64'(exp_upd[1]));
    check("lpf1",   64'(m1.lines_per_frame),   64'(satv(lpf_raw[1], 1)));
    check("ppl1",   64'(m1.pixels_per_line),   64'(satv(ppl_raw, 1)));
    check("stall1", 64'(m1.frame_stall),       64'(exp_stall[1]));
    check("dbg1",   64'(m1.debug_status),      64'(dbg1));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Frame pattern: vsync high for hi cycles, then nl lines of len de-cycles.
  task automatic set_pat(input int c, input int period, input int hi,
                         input int len, input int gap, input int nl);
    int o, li;
    o     = c % period;
    li    = o - (hi + 4);
    vsync = (o < hi);
    de    = (li >= 0) && (li < nl * (len + gap)) && ((li % (len + gap)) < len);
  endtask

  task automatic run_pat(input int n, input int period, input int hi,
                         input int len, input int gap, input int nl);
    for (int c = 0; c < n; c++) begin
      set_pat(c, period, hi, len, gap, nl);
      cyc();
    end
  endtask

  int stall_seen;

  initial begin
    reset = 1'b1; enable = 1'b0; vsync = 1'b0; de = 1'b0;
    t = 0;
    model_reset();
    #3;
    check_all();
    #9 reset = 1'b0;
    enable = 1'b1;

    // 10 frames per window, short lines
    run_pat(2500, 100, 10, 8, 2, 8);
    // 8 lines of 64 pixels with 16-cycle gaps
    run_pat(2100, 700, 10, 64, 16, 8);

    // vsync silent for two windows, then frames resume
    vsync = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      de = ($urandom_range(0, 7) != 0) ? de : ~de;
      cyc();
    end
    stall_seen = m0.frame_stall;
    check("stall_silent", 64'(stall_seen), 64'(1));
    run_pat(2100, 100, 10, 8, 2, 8);

    // 3 frames then a rising edge on the terminal cycle, for two windows
    vsync = 1'b0; de = 1'b0;
    for (int i = 0; i < W && phase() != 0; i++) cyc();
    for (int c = 0; c < 2 * W + 5; c++) begin
      vsync = (phase() == W - 1) ||
              ((phase() >= 600) && (phase() < 900) && ((phase() % 100) < 10));
      de    = (phase() % 50) < 20;
      cyc();
    end

    // enable dropped at window phase 500 for 200 cycles
    vsync = 1'b0;
    for (int i = 0; i < W && phase() != 500; i++) begin
      set_pat(i, 100, 10, 8, 2, 8);
      cyc();
    end
    enable = 1'b0;
    run_pat(200, 100, 10, 8, 2, 8);
    enable = 1'b1;
    run_pat(1200, 100, 10, 8, 2, 8);

    // random stimulus including occasional enable toggles
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 49) == 0) vsync = ~vsync;
      if ($urandom_range(0, 7) == 0) de = ~de;
      if ($urandom_range(0, 799) == 0) enable = ~enable;
      cyc();
    end
    enable = 1'b1;

    // async reset mid-line between clock edges
    vsync = 1'b0; de = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    #2 reset = 1'b0;
    de = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    de = 1'b1;
    for (int c = 0; c < 20; c++) cyc();
    de = 1'b0;
    for (int c = 0; c < 10; c++) cyc();
    check("ppl_sat16", 64'(m0.pixels_per_line), 64'(20));
    check("ppl_sat4",  64'(m1.pixels_per_line), 64'(15));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
